// File: rtl/nios2cpu_ram_pkg.sv
// Shared definitions for the Nios II on-chip RAM burst adapter.
//  - default geometry of the 8192x32 RAM and the largest accepted burst
//  - adapter FSM state encoding
//  - burst_len(): maps a raw burstcount onto the number of beats actually run
package nios2cpu_ram_pkg;

  localparam int ADDR_W_DEF    = 13;
  localparam int DATA_W_DEF    = 32;
  localparam int BE_W_DEF      = DATA_W_DEF / 8;
  localparam int BURST_W_DEF   = 4;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  // Out-of-range burstcounts (0 or above the maximum) degrade to a single beat.
  function automatic int burst_len(input int count, input int max_burst);
    return (count < 1 || count > max_burst) ? 1 : count;
  endfunction

endpackage

// File: rtl/nios2cpu_burst_addr_gen.sv
// Burst address generator: a loadable, wrapping word-address register plus a
// down-counter of beats still to be issued after the first one.
//  clk, reset  : clock, synchronous active-high reset
//  load        : first beat accepted; load_addr+1 / load_beats-1 are captured
//  load_addr   : start address of the burst
//  load_beats  : total beats in the burst (already range-limited)
//  advance     : one further beat issued this cycle
//  addr        : address of the next beat after the first
//  last        : the beat at addr is the final one of the burst
module nios2cpu_burst_addr_gen #(
  parameter int ADDR_W  = 13,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [BURST_W-1:0] load_beats,
  input  logic               advance,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  logic [BURST_W-1:0] remaining;

  // NOTE: these are two plain registers, not a memory array, so both get a reset
  // value; a burst interrupted by reset leaves no stale beat count behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      // Address wraps naturally at 2^ADDR_W.
      addr      <= load_addr + ADDR_W'(1);
      remaining <= load_beats - BURST_W'(1);
    end else if (advance) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - BURST_W'(1);
    end
  end

  assign last = (remaining == BURST_W'(1));

endmodule

// File: rtl/nios2cpu_ram_burst_adapter.sv
// Avalon-MM burst slave in front of the single-port on-chip RAM. Splits read
// and write bursts (1..MAX_BURST beats) into one RAM access per cycle and
// produces readdatavalid from the RAM's fixed one-cycle read latency.
//  s_*  : Avalon-MM slave side (address, byteenable, read, write, writedata,
//         burstcount in; waitrequest, readdata, readdatavalid out)
//  m_*  : RAM side (address, byteenable, chipselect, write, writedata, clken
//         out; readdata in)
//  clk, reset : clock, synchronous active-high reset
module nios2cpu_ram_burst_adapter
  import nios2cpu_ram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BE_W      = BE_W_DEF,
  parameter int BURST_W   = BURST_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  s_address,
  input  logic [BE_W-1:0]    s_byteenable,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [DATA_W-1:0]  s_writedata,
  input  logic [BURST_W-1:0] s_burstcount,
  output logic               s_waitrequest,
  output logic [DATA_W-1:0]  s_readdata,
  output logic               s_readdatavalid,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BE_W-1:0]    m_byteenable,
  output logic               m_chipselect,
  output logic               m_write,
  output logic [DATA_W-1:0]  m_writedata,
  output logic               m_clken,
  input  logic [DATA_W-1:0]  m_readdata
);

  state_t             state;
  logic               wait_q;
  logic               rdv_q;
  logic               clken_q;
  logic               cmd_ok;
  logic               accept_wr;
  logic               accept_rd;
  logic               rd_beat;
  logic               wr_beat;
  logic               rd_issue;
  logic               last;
  logic [BURST_W-1:0] beats;
  logic [ADDR_W-1:0]  burst_addr;

  assign beats = BURST_W'(burst_len(int'(s_burstcount), MAX_BURST));

  // Commands are taken only in IDLE once the post-reset stall has lifted.
  // A simultaneous read and write resolves in favour of the write.
  assign cmd_ok    = (state == IDLE) && !wait_q && !reset;
  assign accept_wr = cmd_ok && s_write;
  assign accept_rd = cmd_ok && s_read && !s_write;
  assign rd_beat   = (state == RD_BURST) && !reset;
  assign wr_beat   = (state == WR_BURST) && s_write && !reset;
  assign rd_issue  = accept_rd || rd_beat;

  nios2cpu_burst_addr_gen #(
    .ADDR_W  (ADDR_W),
    .BURST_W (BURST_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (accept_wr || accept_rd),
    .load_addr  (s_address),
    .load_beats (beats),
    .advance    (rd_beat || wr_beat),
    .addr       (burst_addr),
    .last       (last)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values of state, wait_q and the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wait_q  <= 1'b1;
      rdv_q   <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      clken_q <= 1'b1;
      // RAM q is valid the cycle after its address is registered.
      rdv_q   <= rd_issue;
      case (state)
        IDLE: begin
          wait_q <= 1'b0;
          if (accept_wr && beats != BURST_W'(1)) begin
            state <= WR_BURST;
          end else if (accept_rd && beats != BURST_W'(1)) begin
            state  <= RD_BURST;
            wait_q <= 1'b1;
          end
        end
        RD_BURST: begin
          if (last) begin
            state  <= IDLE;
            wait_q <= 1'b0;
          end else begin
            wait_q <= 1'b1;
          end
        end
        WR_BURST: begin
          wait_q <= 1'b0;
          if (wr_beat && last) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          wait_q <= 1'b0;
        end
      endcase
    end
  end

  // The first beat goes straight from the slave address; later beats come from
  // the generator, giving back-to-back accesses with no dead cycle.
  assign m_address       = (state == IDLE) ? s_address : burst_addr;
  assign m_write         = accept_wr || wr_beat;
  assign m_chipselect    = rd_issue || m_write;
  assign m_byteenable    = m_write ? s_byteenable : '1;
  assign m_writedata     = s_writedata;
  assign m_clken         = clken_q;
  assign s_waitrequest   = wait_q;
  assign s_readdata      = m_readdata;
  assign s_readdatavalid = rdv_q;

endmodule
